// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared FSM state type and width helpers for the N-way cache
package cache_pkg;
   typedef enum logic [1:0] {
      S_IDLE,
      S_RD_MISS,
      S_WR_THRU,
      S_RESP
   } state_e;

   // Zero for a single set so the index field disappears and the tag spans the address.
   function automatic int index_w(input int sets);
      return (sets > 1) ? $clog2(sets) : 0;
   endfunction

   function automatic int age_w(input int ways);
      return $clog2(ways);
   endfunction
endpackage

// File: rtl/cache_lru.sv
// rtl/cache_lru.sv - true-LRU age update and victim selection for one set
module cache_lru #(
   parameter int WAYS  = 2,
   parameter int AGE_W = 1
) (
   input  logic [WAYS*AGE_W-1:0] ages_i,
   input  logic [WAYS-1:0]       valid_i,
   input  logic [AGE_W-1:0]      touch_i,
   output logic [WAYS*AGE_W-1:0] ages_o,
   output logic [AGE_W-1:0]      victim_o
);
   logic [AGE_W-1:0] touch_age;
   logic             found;

   always_comb begin
      touch_age = ages_i[touch_i*AGE_W +: AGE_W];
      ages_o    = ages_i;
      for (int w = 0; w < WAYS; w++) begin
         if (AGE_W'(w) == touch_i) begin
            ages_o[w*AGE_W +: AGE_W] = '0;
         end else if (ages_i[w*AGE_W +: AGE_W] < touch_age) begin
            ages_o[w*AGE_W +: AGE_W] = ages_i[w*AGE_W +: AGE_W] + 1'b1;
         end
      end
   end

   // Prefer the lowest invalid way; otherwise the way whose age is all ones (WAYS-1).
   always_comb begin
      victim_o = '0;
      found    = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!found && !valid_i[w]) begin
            victim_o = AGE_W'(w);
            found    = 1'b1;
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!found && ages_i[w*AGE_W +: AGE_W] == {AGE_W{1'b1}}) begin
            victim_o = AGE_W'(w);
            found    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/cache_nway.sv
// rtl/cache_nway.sv - N-way set-associative write-through, no-write-allocate cache
module cache_nway
   import cache_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int SETS   = 4,
   parameter int WAYS   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   input  logic              flush,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_hit,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);
   localparam int IDX_W = index_w(SETS);
   localparam int SET_W = (IDX_W > 0) ? IDX_W : 1;
   localparam int AGE_W = age_w(WAYS);
   localparam int TAG_W = ADDR_W - IDX_W;

   state_e                state_q, state_d;
   logic [ADDR_W-1:0]     addr_q;
   logic [DATA_W-1:0]     wdata_q;
   logic [DATA_W-1:0]     rdata_q;
   logic                  hit_q;
   logic [WAYS-1:0]       valid_q [SETS];
   logic [TAG_W-1:0]      tag_q   [SETS][WAYS];
   logic [DATA_W-1:0]     data_q  [SETS][WAYS];
   logic [WAYS*AGE_W-1:0] age_q   [SETS];

   logic [SET_W-1:0]      cpu_idx, req_idx, sel_idx;
   logic [TAG_W-1:0]      cpu_tag;
   logic                  hit;
   logic [AGE_W-1:0]      hit_way, victim, touch_way;
   logic [WAYS*AGE_W-1:0] ages_next;
   logic                  accept, do_flush, fill;

   if (IDX_W > 0) begin : g_idx
      assign cpu_idx = cpu_addr[SET_W-1:0];
      assign req_idx = addr_q[SET_W-1:0];
   end else begin : g_no_idx
      assign cpu_idx = '0;
      assign req_idx = '0;
   end
   assign cpu_tag = cpu_addr[ADDR_W-1:IDX_W];

   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[cpu_idx][w] && tag_q[cpu_idx][w] == cpu_tag) begin
            hit     = 1'b1;
            hit_way = AGE_W'(w);
         end
      end
   end

   // In IDLE the LRU sees the incoming request's set; while a fill is pending, the latched one.
   assign sel_idx   = (state_q == S_IDLE) ? cpu_idx : req_idx;
   assign touch_way = (state_q == S_IDLE) ? hit_way : victim;

   cache_lru #(
      .WAYS  (WAYS),
      .AGE_W (AGE_W)
   ) u_lru (
      .ages_i   (age_q[sel_idx]),
      .valid_i  (valid_q[sel_idx]),
      .touch_i  (touch_way),
      .ages_o   (ages_next),
      .victim_o (victim)
   );

   always_comb begin
      state_d   = state_q;
      accept    = 1'b0;
      do_flush  = 1'b0;
      fill      = 1'b0;
      cpu_ready = 1'b0;
      mem_req   = 1'b0;
      mem_wr    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (flush) begin
               do_flush = 1'b1;
            end else if (cpu_req) begin
               accept  = 1'b1;
               state_d = cpu_wr ? S_WR_THRU : (hit ? S_RESP : S_RD_MISS);
            end
         end
         S_RD_MISS: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               fill    = 1'b1;
               state_d = S_RESP;
            end
         end
         S_WR_THRU: begin
            mem_req = 1'b1;
            mem_wr  = 1'b1;
            if (mem_ack) state_d = S_RESP;
         end
         S_RESP: begin
            cpu_ready = 1'b1;
            state_d   = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign cpu_hit   = cpu_ready & hit_q;
   assign cpu_rdata = rdata_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         hit_q   <= 1'b0;
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               tag_q[s][w]                 <= '0;
               data_q[s][w]                <= '0;
               age_q[s][w*AGE_W +: AGE_W]  <= AGE_W'(w);
            end
         end
      end else begin
         if (do_flush) begin
            for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
         end
         if (accept) begin
            addr_q  <= cpu_addr;
            wdata_q <= cpu_wdata;
            hit_q   <= hit;
            if (hit) begin
               age_q[cpu_idx] <= ages_next;
               if (cpu_wr) data_q[cpu_idx][hit_way] <= cpu_wdata;
               else        rdata_q                  <= data_q[cpu_idx][hit_way];
            end
         end
         if (fill) begin
            valid_q[req_idx][victim] <= 1'b1;
            tag_q[req_idx][victim]   <= addr_q[ADDR_W-1:IDX_W];
            data_q[req_idx][victim]  <= mem_rdata;
            age_q[req_idx]           <= ages_next;
            rdata_q                  <= mem_rdata;
         end
      end
   end
endmodule
